// File: rtl/inst_buffer_nway_if.sv
// inst_buffer_nway_if: fetch/dispatch bundle between the front end and the instruction buffer
interface inst_buffer_nway_if #(
  parameter int DEPTH  = 16,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int DATA_W = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TK_W  = $clog2(OUT_W + 1);
  logic                    flush;
  logic [IN_W-1:0]         in_valid;
  logic [IN_W*DATA_W-1:0]  in_data;
  logic                    in_ready;
  logic [OUT_W-1:0]        out_valid;
  logic [OUT_W*DATA_W-1:0] out_data;
  logic [TK_W-1:0]         out_take;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        free_cnt;
  logic                    full;
  logic                    empty;
  modport master (
    output flush, in_valid, in_data, out_take,
    input  in_ready, out_valid, out_data, count, free_cnt, full, empty
  );
  modport slave (
    input  flush, in_valid, in_data, out_take,
    output in_ready, out_valid, out_data, count, free_cnt, full, empty
  );
endinterface

// File: rtl/inst_buffer_nway.sv
// inst_buffer_nway: multi-lane circular instruction buffer between fetch and dispatch, FWFT output
module inst_buffer_nway #(
  parameter int DEPTH  = 16,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int DATA_W = 64
) (
  input logic               clock,
  input logic               reset,
  inst_buffer_nway_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CNT_W-1:0]  cnt, free, n_lead, n_in, n_out, take;
  logic              ready, run;

  // pointer + offset modulo DEPTH; offsets never exceed DEPTH so one subtract suffices
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [CNT_W-1:0] k);
    logic [CNT_W:0] s;
    s = (CNT_W+1)'(p) + (CNT_W+1)'(k);
    return PW'((s >= (CNT_W+1)'(DEPTH)) ? s - (CNT_W+1)'(DEPTH) : s);
  endfunction

  assign free  = CNT_W'(DEPTH) - cnt;
  assign ready = free >= CNT_W'(IN_W);
  assign take  = CNT_W'(bus.out_take);
  assign n_in  = ready ? n_lead : '0;
  assign n_out = (take < cnt) ? take : cnt;

  always_comb begin
    n_lead = '0;
    run    = 1'b1;
    for (int i = 0; i < IN_W; i++) begin
      run    = run & bus.in_valid[i];
      n_lead = n_lead + (run ? CNT_W'(1) : CNT_W'(0));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < IN_W; i++)
        if (CNT_W'(i) < n_in) mem[wrap(tail, CNT_W'(i))] <= bus.in_data[i*DATA_W +: DATA_W];
      tail <= wrap(tail, n_in);
      head <= wrap(head, n_out);
      cnt  <= cnt + n_in - n_out;
    end
  end

  for (genvar j = 0; j < OUT_W; j++) begin : g_out
    assign bus.out_valid[j] = cnt > CNT_W'(j);
    assign bus.out_data[j*DATA_W +: DATA_W] = bus.out_valid[j] ? mem[wrap(head, CNT_W'(j))] : '0;
  end

  assign bus.in_ready = ready;
  assign bus.count    = cnt;
  assign bus.free_cnt = free;
  assign bus.full     = cnt == CNT_W'(DEPTH);
  assign bus.empty    = cnt == '0;
endmodule
